stopwatch_core: RTL and testbench

- Timekeeping stage directly downstream of the start/stop state-hold latch.
- Consumes the latched `state` level: 0 = run, 1 = halt.
- Divides clk_50MHz down to a 10 ms tick and advances a BCD time value MM:SS.cc (minutes, seconds, centiseconds).
- Drives the display/mux stage with six BCD digits, plus tick and wrap strobes.

---
 rtl/stopwatch_pkg.sv | 7 +
 rtl/stopwatch_core_bcd_digit_cnt.sv | 28 ++
 rtl/stopwatch_core.sv | 86 ++++++++
 tb/tb_stopwatch_core.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch timekeeping stage: digit width, digit limits, default divider.
package stopwatch_pkg;
  localparam int TICK_DIV_50MHZ = 500000;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] MAX_DEC = 4'd9;
  localparam logic [DIGIT_W-1:0] MAX_SEX = 4'd5;
endpackage

// File: rtl/stopwatch_core_bcd_digit_cnt.sv
// One BCD digit of the time value: counts 0..MAX on en and raises a combinational carry at MAX.
// The count is registered; carry is same-cycle, so a chain of these ripples within one edge. No backpressure.
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = MAX_DEC
) (
  input  logic               clk_50MHz,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry
);

  assign carry = en && (digit == MAX);

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (en) begin
      digit <= (digit == MAX) ? '0 : digit + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Divides clk_50MHz to a 10 ms count event and advances an MM:SS.cc BCD time while state = 0 (run).
// Digits, tick and wrap update on the event edge; tick/wrap are registered strobes. No backpressure.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_50MHZ,
  parameter int PRE_W    = 19
) (
  input  logic               clk_50MHz,
  input  logic               rst,
  input  logic               state,
  input  logic               clr,
  output logic [DIGIT_W-1:0] cs_ones,
  output logic [DIGIT_W-1:0] cs_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] min_tens,
  output logic               tick,
  output logic               wrap,
  output logic               running
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre;
  logic             count_en;
  logic [5:0]       carry;

  // A halted prescaler keeps its partial interval so resume does not lose time.
  assign count_en = !clr && !state && (pre == PRE_LAST);

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (clr) begin
      pre <= '0;
    end else if (!state) begin
      pre <= count_en ? '0 : pre + 1'b1;
    end
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      tick    <= 1'b0;
      wrap    <= 1'b0;
      running <= 1'b0;
    end else begin
      tick    <= count_en;
      wrap    <= carry[5];
      running <= !state;
    end
  end

  // carry[5] is only high when every digit sits at its max during an event: 59:59.99 -> 00:00.00.
  bcd_digit_cnt #(.MAX(MAX_DEC)) u_cs_ones (
    .clk_50MHz(clk_50MHz), .rst(rst), .clr(clr), .en(count_en),
    .digit(cs_ones), .carry(carry[0])
  );

  bcd_digit_cnt #(.MAX(MAX_DEC)) u_cs_tens (
    .clk_50MHz(clk_50MHz), .rst(rst), .clr(clr), .en(carry[0]),
    .digit(cs_tens), .carry(carry[1])
  );

  bcd_digit_cnt #(.MAX(MAX_DEC)) u_sec_ones (
    .clk_50MHz(clk_50MHz), .rst(rst), .clr(clr), .en(carry[1]),
    .digit(sec_ones), .carry(carry[2])
  );

  bcd_digit_cnt #(.MAX(MAX_SEX)) u_sec_tens (
    .clk_50MHz(clk_50MHz), .rst(rst), .clr(clr), .en(carry[2]),
    .digit(sec_tens), .carry(carry[3])
  );

  bcd_digit_cnt #(.MAX(MAX_DEC)) u_min_ones (
    .clk_50MHz(clk_50MHz), .rst(rst), .clr(clr), .en(carry[3]),
    .digit(min_ones), .carry(carry[4])
  );

  bcd_digit_cnt #(.MAX(MAX_SEX)) u_min_tens (
    .clk_50MHz(clk_50MHz), .rst(rst), .clr(clr), .en(carry[4]),
    .digit(min_tens), .carry(carry[5])
  );

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: TICK_DIV=4 instance with a per-cycle scoreboard, TICK_DIV=1 instance for the full wrap.
module tb_stopwatch_core;

  localparam int TD = 4;
  localparam int FULL = 360000;

  logic clk_50MHz = 1'b0;
  always #5 clk_50MHz = ~clk_50MHz;

  logic rst, state, clr;
  logic [3:0] cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens;
  logic tick, wrap, running;

  logic rst_w, state_w, clr_w;
  logic [3:0] w_cs1, w_cs10, w_s1, w_s10, w_m1, w_m10;
  logic tick_w, wrap_w, running_w;

  stopwatch_core #(.TICK_DIV(TD), .PRE_W(3)) dut (
    .clk_50MHz(clk_50MHz), .rst(rst), .state(state), .clr(clr),
    .cs_ones(cs_ones), .cs_tens(cs_tens), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens),
    .tick(tick), .wrap(wrap), .running(running)
  );

  stopwatch_core #(.TICK_DIV(1), .PRE_W(1)) dut_w (
    .clk_50MHz(clk_50MHz), .rst(rst_w), .state(state_w), .clr(clr_w),
    .cs_ones(w_cs1), .cs_tens(w_cs10), .sec_ones(w_s1), .sec_tens(w_s10),
    .min_ones(w_m1), .min_tens(w_m10),
    .tick(tick_w), .wrap(wrap_w), .running(running_w)
  );

  logic [23:0] disp, disp_w;
  assign disp   = {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones};
  assign disp_w = {w_m10, w_m1, w_s10, w_s1, w_cs10, w_cs1};

  typedef struct packed {
    logic [23:0] t;
    logic        tick;
    logic        wrap;
    logic        running;
  } exp_t;

  typedef struct {
    logic        s;
    logic        c;
    int          n;
    logic [23:0] t;
    int          ticks;
    logic        run;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[14];
  int checks = 0;
  int errors = 0;
  int m_pre, m_cs;

  function automatic logic [23:0] to_bcd(input int c);
    int cs, s, m;
    cs = c % 100;
    s  = (c / 100) % 60;
    m  = c / 6000;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, push the model's prediction, then compare after the edge.
  task automatic step(input logic s, input logic c);
    exp_t e, g;
    logic ev;
    state = s;
    clr   = c;
    ev = !c && !s && (m_pre == TD - 1);
    e.wrap = ev && (m_cs == FULL - 1);
    e.tick = ev;
    e.running = !s;
    if (c) m_pre = 0;
    else if (!s) m_pre = ev ? 0 : m_pre + 1;
    if (c) m_cs = 0;
    else if (ev) m_cs = (m_cs + 1) % FULL;
    e.t = to_bcd(m_cs);
    sb.push_back(e);
    @(posedge clk_50MHz);
    #1;
    g = '{t: disp, tick: tick, wrap: wrap, running: running};
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("scoreboard", 32'(g), 32'(e));
    end
  endtask

  initial begin
    int tk, first, bad, bad_tick, wraps, wrap_k;
    rst = 1'b1; state = 1'b1; clr = 1'b0;
    rst_w = 1'b1; state_w = 1'b1; clr_w = 1'b0;
    m_pre = 0; m_cs = 0;

    vecs[0]  = '{1'b1, 1'b0, 100,  24'h000000, 0,   1'b0};
    vecs[1]  = '{1'b0, 1'b0, 400,  24'h000100, 100, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 1,    24'h000000, 0,   1'b1};
    vecs[3]  = '{1'b0, 1'b0, 6,    24'h000001, 1,   1'b1};
    vecs[4]  = '{1'b1, 1'b0, 50,   24'h000001, 0,   1'b0};
    vecs[5]  = '{1'b0, 1'b0, 2,    24'h000002, 1,   1'b1};
    vecs[6]  = '{1'b0, 1'b0, 3,    24'h000002, 0,   1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1,    24'h000002, 0,   1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1,    24'h000003, 1,   1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1,    24'h000000, 0,   1'b0};
    vecs[10] = '{1'b1, 1'b0, 5,    24'h000000, 0,   1'b0};
    vecs[11] = '{1'b0, 1'b0, 2168, 24'h000542, 542, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 3,    24'h000542, 0,   1'b1};
    vecs[13] = '{1'b0, 1'b1, 1,    24'h000000, 0,   1'b1};

    #1;
    check("async_rst_digits", 32'(disp), 32'h0);
    check("async_rst_strobes", {29'd0, tick, wrap, running}, 32'h0);
    repeat (3) @(posedge clk_50MHz);
    #1;
    check("rst_hold_digits", 32'(disp), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      tk = 0;
      for (int j = 0; j < vecs[i].n; j++) begin
        step(vecs[i].s, vecs[i].c);
        if (tick === 1'b1) tk++;
      end
      check($sformatf("vec%0d_time", i), 32'(disp), 32'(vecs[i].t));
      check($sformatf("vec%0d_ticks", i), tk, vecs[i].ticks);
      check($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].run));
    end

    // Async reset mid-count, then the first tick must take a full TD cycles.
    for (int j = 0; j < 10; j++) step(1'b0, 1'b0);
    check("pre_reset_time", 32'(disp), 32'h000002);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_digits", 32'(disp), 32'h0);
    check("mid_rst_strobes", {29'd0, tick, wrap, running}, 32'h0);
    #1 rst = 1'b0;
    m_pre = 0; m_cs = 0;
    first = 0;
    for (int j = 1; j <= 10 && first == 0; j++) begin
      step(1'b0, 1'b0);
      if (tick === 1'b1) first = j;
    end
    check("first_tick_after_rst", first, TD);
    check("first_tick_time", 32'(disp), 32'h000001);

    // Full 60-minute roll on the divide-by-1 instance.
    state = 1'b1;
    bad = 0; bad_tick = 0; wraps = 0; wrap_k = 0;
    state_w = 1'b0;
    rst_w = 1'b0;
    for (int k = 1; k <= FULL; k++) begin
      @(posedge clk_50MHz);
      #1;
      if (disp_w !== to_bcd(k % FULL)) bad++;
      if (tick_w !== 1'b1) bad_tick++;
      if (wrap_w === 1'b1) begin
        wraps++;
        wrap_k = k;
        if (tick_w !== 1'b1) bad_tick++;
      end
      if (k == 75456) check("w_time_123456", 32'(disp_w), 32'h123456);
      if (k == FULL - 1) check("w_time_595999", 32'(disp_w), 32'h595999);
    end
    check("w_track_mismatches", bad, 0);
    check("w_tick_missing", bad_tick, 0);
    check("w_wrap_count", wraps, 1);
    check("w_wrap_cycle", wrap_k, FULL);
    check("w_after_wrap", 32'(disp_w), 32'h0);

    repeat (5) @(posedge clk_50MHz);
    #1;
    check("w_resume_time", 32'(disp_w), 32'h000005);
    #3 rst_w = 1'b1;
    #1;
    check("w_mid_rst_digits", 32'(disp_w), 32'h0);
    check("w_mid_rst_strobes", {29'd0, tick_w, wrap_w, running_w}, 32'h0);
    #1 rst_w = 1'b0;
    @(posedge clk_50MHz);
    #1;
    check("w_post_rst_tick", {30'd0, tick_w, running_w}, 32'h3);
    check("w_post_rst_time", 32'(disp_w), 32'h000001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
